// File: rtl/dot_acc.sv
// Accumulates LEN unsigned 16-bit products into a saturating ACC_W-bit sum and
// presents the completed dot product with a valid/ready handshake.
module dot_acc #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  // The counter is one bit wider than the port so that LEN=256 can still be
  // detected; the count port then reads 0 while holding a 256-product result.
  localparam logic [8:0]       LAST    = 9'(LEN);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state, stateNext;
  logic [ACC_W-1:0] acc, accNext;
  logic [8:0]       cnt, cntNext;
  logic             ovfReg, ovfNext;
  logic             accept;
  logic [ACC_W:0]   sum;

  assign accept = in_valid && (state != HOLD);
  assign sum    = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};

  // State register: reset dominates everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovfReg <= 1'b0;
    end else begin
      state  <= stateNext;
      acc    <= accNext;
      cnt    <= cntNext;
      ovfReg <= ovfNext;
    end
  end

  // Next-state logic: clear aborts the vector before any accept or handshake.
  always_comb begin
    stateNext = state;
    accNext   = acc;
    cntNext   = cnt;
    ovfNext   = ovfReg;
    if (clear) begin
      stateNext = IDLE;
      accNext   = '0;
      cntNext   = '0;
      ovfNext   = 1'b0;
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (accept) begin
            cntNext = cnt + 9'd1;
            // Once saturated the sum stays pinned for the rest of the vector.
            if (ovfReg || sum[ACC_W]) begin
              accNext = ACC_MAX;
              ovfNext = 1'b1;
            end else begin
              accNext = sum[ACC_W-1:0];
            end
            stateNext = (cntNext == LAST) ? HOLD : ACC;
          end
        end
        HOLD: begin
          if (out_ready) begin
            stateNext = IDLE;
            accNext   = '0;
            cntNext   = '0;
            ovfNext   = 1'b0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign acc_out   = (state == HOLD) ? acc : '0;
  assign ovf       = ovfReg;
  assign count     = cnt[7:0];

endmodule

// File: tb/tb_dot_acc.sv
// Randomized and directed bench for dot_acc: instance 0 uses LEN=8/ACC_W=24,
// instance 1 uses LEN=4/ACC_W=17 to reach saturation quickly.
module tb_dot_acc;

  logic        clk;
  logic        rst;
  logic [15:0] prod[2];
  logic        inValid[2];
  logic        clear[2];
  logic        outReady[2];

  logic        inReady[2];
  logic        outValid[2];
  logic        ovfOut[2];
  logic [7:0]  countOut[2];
  logic [23:0] acc0;
  logic [16:0] acc1;

  int checks = 0;
  int errors = 0;

  // Reference model: the current vector is just a list length and a total.
  int     mItems[2];
  longint mTotal[2];
  bit     mHold[2];
  int     lenOf[2] = '{8, 4};
  longint maxOf[2] = '{64'd16777215, 64'd131071};

  dot_acc #(.LEN(8), .ACC_W(24)) dut0 (
    .clk(clk), .rst(rst), .prod(prod[0]), .in_valid(inValid[0]),
    .in_ready(inReady[0]), .clear(clear[0]), .acc_out(acc0), .ovf(ovfOut[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .count(countOut[0])
  );

  dot_acc #(.LEN(4), .ACC_W(17)) dut1 (
    .clk(clk), .rst(rst), .prod(prod[1]), .in_valid(inValid[1]),
    .in_ready(inReady[1]), .clear(clear[1]), .acc_out(acc1), .ovf(ovfOut[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .count(countOut[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic longint obsAcc(input int d);
    return (d == 0) ? longint'(acc0) : longint'(acc1);
  endfunction

  task automatic compareDut(input int d);
    longint sat;
    sat = (mTotal[d] > maxOf[d]) ? maxOf[d] : mTotal[d];
    checkOutput($sformatf("dut%0d.in_ready", d),  longint'(inReady[d]),  longint'(!mHold[d]));
    checkOutput($sformatf("dut%0d.out_valid", d), longint'(outValid[d]), longint'(mHold[d]));
    checkOutput($sformatf("dut%0d.acc_out", d),   obsAcc(d),             mHold[d] ? sat : 0);
    checkOutput($sformatf("dut%0d.ovf", d),       longint'(ovfOut[d]),   longint'(mTotal[d] > maxOf[d]));
    checkOutput($sformatf("dut%0d.count", d),     longint'(countOut[d]), longint'(mItems[d] % 256));
  endtask

  // One clock: the model consumes the inputs seen at the edge, then both
  // instances are compared 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || clear[d] || (mHold[d] && outReady[d])) begin
        mItems[d] = 0;
        mTotal[d] = 0;
        mHold[d]  = 0;
      end else if (!mHold[d] && inValid[d]) begin
        mTotal[d] += longint'(prod[d]);
        mItems[d]++;
        if (mItems[d] == lenOf[d]) mHold[d] = 1;
      end
    end
    #1;
    compareDut(0);
    compareDut(1);
  endtask

  task automatic idleInputs();
    for (int d = 0; d < 2; d++) begin
      prod[d] = '0; inValid[d] = 0; clear[d] = 0; outReady[d] = 0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mItems[d] = 0; mTotal[d] = 0; mHold[d] = 0;
    end
    idleInputs();
    rst = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
    checkOutput("reset.in_ready", longint'(inReady[0]), 1);
    checkOutput("reset.count", longint'(countOut[0]), 0);

    // Full-scale vector.
    inValid[0] = 1; prod[0] = 16'hFE01;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("full.out_valid", longint'(outValid[0]), 1);
    checkOutput("full.acc_out", longint'(acc0), 64'h07F008);
    checkOutput("full.ovf", longint'(ovfOut[0]), 0);
    checkOutput("full.count", longint'(countOut[0]), 8);

    // Backpressure while holding, then handshake and a deferred accept.
    prod[0] = 16'd5;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("bp.acc_stable", longint'(acc0), 64'h07F008);
      checkOutput("bp.in_ready", longint'(inReady[0]), 0);
    end
    outReady[0] = 1;
    applyStimulus();
    checkOutput("bp.release_count", longint'(countOut[0]), 0);
    checkOutput("bp.release_valid", longint'(outValid[0]), 0);
    outReady[0] = 0;
    applyStimulus();
    checkOutput("bp.next_accept", longint'(countOut[0]), 1);
    inValid[0] = 0; clear[0] = 1;
    applyStimulus();
    clear[0] = 0;

    // Clear mid-vector drops the same-cycle product.
    inValid[0] = 1;
    prod[0] = 16'd3; applyStimulus();
    prod[0] = 16'd5; applyStimulus();
    prod[0] = 16'd7; applyStimulus();
    prod[0] = 16'd9; clear[0] = 1; applyStimulus();
    checkOutput("clear.count", longint'(countOut[0]), 0);
    clear[0] = 0; prod[0] = 16'd1;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("clear.acc_out", longint'(acc0), 8);
    inValid[0] = 0; outReady[0] = 1;
    applyStimulus();
    outReady[0] = 0;

    // Gapped input: out_valid must rise exactly after the eighth accept.
    for (int i = 1; i <= 8; i++) begin
      inValid[0] = 1; prod[0] = 16'(i);
      applyStimulus();
      checkOutput("gap.out_valid", longint'(outValid[0]), (i == 8) ? 1 : 0);
      inValid[0] = 0;
      applyStimulus();
    end
    checkOutput("gap.acc_out", longint'(acc0), 36);

    // Reset while a result is pending.
    rst = 1;
    applyStimulus();
    rst = 0;
    checkOutput("rsthold.out_valid", longint'(outValid[0]), 0);
    checkOutput("rsthold.acc_out", longint'(acc0), 0);
    checkOutput("rsthold.count", longint'(countOut[0]), 0);
    checkOutput("rsthold.in_ready", longint'(inReady[0]), 1);

    // Saturation on the narrow instance.
    inValid[1] = 1; prod[1] = 16'hFE01;
    for (int i = 0; i < 3; i++) applyStimulus();
    prod[1] = 16'h0001;
    applyStimulus();
    checkOutput("sat.acc_out", longint'(acc1), 64'h1FFFF);
    checkOutput("sat.ovf", longint'(ovfOut[1]), 1);
    inValid[1] = 0; outReady[1] = 1;
    applyStimulus();
    outReady[1] = 0; inValid[1] = 1; prod[1] = 16'd2;
    applyStimulus();
    checkOutput("sat.next_ovf", longint'(ovfOut[1]), 0);
    inValid[1] = 0;

    // Randomized traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        inValid[d]  = ($urandom_range(0, 3) != 0);
        prod[d]     = 16'($urandom);
        clear[d]    = ($urandom_range(0, 24) == 0);
        outReady[d] = ($urandom_range(0, 2) != 0);
      end
      applyStimulus();
    end
    rst = 0;
    idleInputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_acc.md
DOT_ACC -- requirements
Module: dot_acc

Interface
REQ-001 SHALL have parameter LEN, default 8: number of products per dot-product vector, legal range 2..256.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width, legal range 17..32.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port prod, input, 16 bits: unsigned product from the upstream 8x8 array multiplier.
REQ-006 SHALL have port in_valid, input, 1 bit: prod is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts prod this cycle.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abort of the current vector.
REQ-009 SHALL have port acc_out, output, ACC_W bits: completed dot-product sum.
REQ-010 SHALL have port ovf, output, 1 bit: the completed sum saturated.
REQ-011 SHALL have port out_valid, output, 1 bit: acc_out and ovf are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-013 SHALL have port count, output, 8 bits: number of products accepted in the current vector.

Function
REQ-014 SHALL implement states IDLE (count=0), ACC (0<count<LEN) and HOLD (result presented).
REQ-015 SHALL define an accept as in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-016 SHALL, on each accept, add zero-extended prod to the accumulator and increment count by 1.
REQ-017 SHALL move IDLE->ACC on the first accept, ACC->ACC on further accepts, and IDLE/ACC->HOLD on the accept that makes count reach LEN.
REQ-018 SHALL, in HOLD, assert out_valid=1 with acc_out, ovf and count=LEN held stable; first out_valid occurs the cycle after the LEN-th accept.
REQ-019 SHALL, in HOLD with out_ready=1, return to IDLE next cycle with the accumulator, ovf and count zeroed and out_valid=0.
REQ-020 SHALL, in HOLD, not accept the same-cycle in_valid, even when out_ready=1; that product is accepted no earlier than the next cycle in IDLE.
REQ-021 SHALL saturate the accumulator at 2^ACC_W-1 if an addition carries out of ACC_W bits, set sticky ovf=1 for the rest of the vector, and ignore further additions.
REQ-022 SHALL drive out_valid=0 and acc_out=0 outside HOLD; the partial sum is internal only.
REQ-023 SHALL, on clear=1 in any state, go to IDLE next cycle with the accumulator, count and ovf zeroed and out_valid=0.
REQ-024 SHALL give clear priority over a same-cycle accept (the product is dropped) and over out_ready.
REQ-025 SHALL ignore prod when in_valid=0, and SHALL ignore out_ready outside HOLD.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE with accumulator=0, count=0, ovf=0, out_valid=0, acc_out=0 and in_ready=1 from the following cycle.
REQ-027 SHALL give rst priority over clear, in_valid and out_ready; rst in HOLD discards the pending result without handshake.

Verification
REQ-028 SHALL verify full-scale vector: LEN=8, eight back-to-back accepts of prod=0xFE01 -> next cycle out_valid=1, acc_out=0x07F008, ovf=0, count=8.
REQ-029 SHALL verify backpressure: result pending with out_ready=0 for 3 cycles and in_valid=1 -> acc_out stable, in_ready=0 throughout; out_ready=1 -> IDLE, count=0, next prod accepted the cycle after.
REQ-030 SHALL verify clear mid-vector: accept 3, 5 and 7, then clear=1 with in_valid=1 and prod=9 -> count=0 and the 9 dropped; then eight accepts of 1 -> acc_out=8.
REQ-031 SHALL verify saturation: ACC_W=17, LEN=4, products 0xFE01, 0xFE01, 0xFE01, 0x0001 -> acc_out=0x1FFFF, ovf=1; the next vector starts with ovf=0.
REQ-032 SHALL verify reset in HOLD: rst=1 for one cycle while out_valid=1 -> out_valid=0, acc_out=0, count=0, in_ready=1 the following cycle.
REQ-033 SHALL verify gapped input: LEN=8, in_valid toggling 1/0 with products 1..8 -> acc_out=36, with out_valid asserted exactly one cycle after the eighth accept.
